ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It is the outbound counterpart of the keycode receive path and sends command bytes to the keyboard, for example 0xED set-LEDs, 0xF4 enable, or 0xFF reset. It takes one byte per handshake from the game processor and runs the full inhibit, request, clocked-shift and acknowledge sequence on the shared open-drain PS/2 clock and data lines. It reports completion or failure with one-cycle pulses.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_line_sync.sv | 42 ++++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame layout and common
// keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_REL = 3'd5
  } ps2_state_e;

  localparam int         DATA_BITS  = 8;
  localparam logic [3:0] PARITY_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX   = 4'd9;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Logic level of frame position idx after the start bit: data LSB first,
  // then parity, then the stop bit.
  function automatic logic frame_bit(input logic [7:0] data, input logic parity,
                                     input logic [3:0] idx);
    if (idx < 4'(DATA_BITS)) frame_bit = data[idx[2:0]];
    else if (idx == PARITY_IDX) frame_bit = parity;
    else frame_bit = 1'b1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines and flags falling edges of
// the synchronized clock. Shared with the receive path.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  // SYNC_STAGES must be at least 2 for the shift concatenation below.
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], dat_in};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign clk_fall = clk_prev_q & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// shift of start/data/parity/stop, then acknowledge check and line release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  // Handshake: a byte moves when cmd_valid and cmd_ready are both high on a
  // rising clk edge; cmd_ready is high only in IDLE and nothing is queued.
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output ps2_state_e state_dbg
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             ack_ok_q, ack_ok_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;

  logic clk_s, dat_s, clk_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  logic timed_state, timeout;
  assign timed_state = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_REL);
  assign timeout     = timed_state && !clk_fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_ok_d  = ack_ok_q;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;

    if (timed_state) cnt_d = clk_fall ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d   = cmd_data;
          par_d    = ~^cmd_data;
          idx_d    = 4'd0;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          ack_ok_d = 1'b0;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          state_d  = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          dat_oe_d = ~frame_bit(data_q, par_q, idx_q);
          if (idx_q == STOP_IDX) state_d = ST_ACK;
          else idx_d = idx_q + 4'd1;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          ack_ok_d = ~dat_s;
          tx_err_d = dat_s;
          state_d  = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (clk_s && dat_s) begin
          tx_done_d = ack_ok_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A frame whose ack already failed does not report a second error.
    if (timeout && !(state_q == ST_WAIT_REL && clk_s && dat_s)) begin
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      tx_done_d = 1'b0;
      tx_err_d  = !(state_q == ST_WAIT_REL && !ack_ok_q);
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_ok_q  <= ack_ok_d;
      tx_done_q <= tx_done_d;
      tx_err_q  <= tx_err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a clocking keyboard model
// and an expected-bit queue built from the byte with plain arithmetic.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 600;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err;
  ps2_state_e state_dbg;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = !(ps2_clk_oe || dev_clk_low);
  assign ps2_dat_line = !(ps2_dat_oe || dev_dat_low);

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ready_bad = 0;
  int half = 15;
  logic [0:0] exp_q[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .state_dbg  (state_dbg)
  );

  // Clock and pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (busy === 1'b1 && cmd_ready === 1'b1) ready_bad++;
  end

  // Reference frame: start 0, data LSB first, odd parity, stop 1
  task automatic model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(1'((b >> i) & 8'h01));
      ones += int'((b >> i) & 8'h01);
    end
    exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
  endtask

  task automatic drive_cmd(input logic [7:0] b, input bit hold);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait got cmd_ready=%0b exp=1", cmd_ready);
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Called at #1 after the accepting edge
  task automatic check_request();
    int n;
    checks++;
    if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) begin
      failures++;
      $display("FAIL accept_latency got clk_oe=%0b dat_oe=%0b exp 1/0", ps2_clk_oe, ps2_dat_oe);
    end
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < INH + 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != INH) begin
      failures++;
      $display("FAIL inhibit_len got=%0d exp=%0d", n, INH);
    end
    checks++;
    if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) begin
      failures++;
      $display("FAIL req_start got clk_oe=%0b dat_oe=%0b exp 1/1", ps2_clk_oe, ps2_dat_oe);
    end
    @(posedge clk); #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
      failures++;
      $display("FAIL req_release got clk_oe=%0b dat_oe=%0b exp 0/1", ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  // Keyboard model: samples on rising clock edges, optionally drives the ack
  task automatic dev_clock(input int npulse, input bit do_ack);
    logic [0:0] e;
    checks++;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
    if (ps2_dat_line !== e) begin
      failures++;
      $display("FAIL start_bit got=%0b exp=%0b", ps2_dat_line, e);
    end
    for (int k = 0; k < npulse; k++) begin
      if (k == 10 && do_ack) dev_dat_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k < 10) begin
        checks++;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
        if (ps2_dat_line !== e) begin
          failures++;
          $display("FAIL frame_bit%0d got=%0b exp=%0b", k, ps2_dat_line, e);
        end
      end
    end
    repeat (half) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_wait got busy=%0b exp=0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit do_ack);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    model_frame(b);
    drive_cmd(b, 1'b0);
    check_request();
    dev_clock(11, do_ack);
    wait_idle();
    checks++;
    if (done_cnt - d0 != (do_ack ? 1 : 0) || err_cnt - e0 != (do_ack ? 0 : 1)) begin
      failures++;
      $display("FAIL frame_%02h_result got done=%0d err=%0d exp done=%0d err=%0d",
               b, done_cnt - d0, err_cnt - e0, do_ack ? 1 : 0, do_ack ? 0 : 1);
    end
    checks++;
    if (cmd_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      failures++;
      $display("FAIL frame_%02h_end got ready=%0b clk_oe=%0b dat_oe=%0b exp 1/0/0",
               b, cmd_ready, ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 ||
        busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got ready=%0b clk_oe=%0b dat_oe=%0b busy=%0b done=%0b err=%0b st=%0d",
               cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err, state_dbg);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_set_leds();
    run_frame(CMD_SET_LEDS, 1'b1);
  endtask

  task automatic test_enable();
    run_frame(CMD_ENABLE, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      half = int'($urandom_range(6, 25));
      run_frame(8'($urandom_range(0, 255)), 1'b1);
    end
    half = 15;
  endtask

  task automatic test_timeout();
    int n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_cmd(CMD_ENABLE, 1'b0);
    check_request();
    n = 0;
    while (tx_err !== 1'b1 && n < TO + 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != TO) begin
      failures++;
      $display("FAIL timeout_len got=%0d exp=%0d", n, TO);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL timeout_release got clk_oe=%0b dat_oe=%0b st=%0d exp 0/0/0",
               ps2_clk_oe, ps2_dat_oe, state_dbg);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL timeout_pulses got done=%0d err=%0d exp 0/1", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_no_ack();
    run_frame(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_busy_ignore();
    int n, r0, d0;
    r0 = ready_bad;
    d0 = done_cnt;
    model_frame(CMD_SET_LEDS);
    drive_cmd(CMD_SET_LEDS, 1'b1);
    cmd_data = CMD_RESET;
    check_request();
    dev_clock(11, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || tx_done !== 1'b1) begin
      failures++;
      $display("FAIL busy_idle_gap got busy=%0b ready=%0b done=%0b exp 0/1/1", busy, cmd_ready, tx_done);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (ready_bad != r0) begin
      failures++;
      $display("FAIL busy_ready got=%0d exp=0 cycles with ready while busy", ready_bad - r0);
    end
    model_frame(CMD_RESET);
    check_request();
    dev_clock(11, 1'b1);
    wait_idle();
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL busy_done_count got=%0d exp=2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = CMD_SET_LEDS;
    model_frame(b);
    drive_cmd(b, 1'b0);
    check_request();
    dev_clock(5, 1'b0);
    @(negedge clk);
    checks++;
    if (ps2_dat_oe !== ~b[4]) begin
      failures++;
      $display("FAIL bit4_drive got dat_oe=%0b exp=%0b", ps2_dat_oe, ~b[4]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      failures++;
      $display("FAIL async_release got clk_oe=%0b dat_oe=%0b exp 0/0", ps2_clk_oe, ps2_dat_oe);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL post_reset got busy=%0b ready=%0b st=%0d exp 0/1/0", busy, cmd_ready, state_dbg);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_enable();
    test_random();
    test_timeout();
    test_no_ack();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
